// File: rtl/reflect_8n_pkg.sv
// Shared CRC constants and the window-size helper used by the reflection datapath.
package reflect_8n_pkg;

    localparam int CRC_MAX_BITS       = 32;
    localparam int CRC_MAX_BYTES      = 4;
    localparam int CRC_MAX_BYTE_WIDTH = 2;

    // Window size in bytes for a bytewidth code; codes past the maximum clamp to it.
    function automatic int window_bytes(input int bytewidth, input int max_bytes);
        int w;
        w = bytewidth + 1;
        if (w > max_bytes) begin
            w = max_bytes;
        end
        return w;
    endfunction

endpackage

// File: rtl/reflect_8n_reflect8.sv
// Combinational 8-bit bit reversal: out[i] = in[7-i].
module reflect_8n_reflect8 (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Mirror each bit position across the byte.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            out_byte[i] = in_byte[7 - i];
        end
    end

endmodule

// File: rtl/reflect_8n.sv
// Registered bit-reflection of the low (bytewidth+1)*8 bits of a word, zero-filled above.
module reflect_8n
    import reflect_8n_pkg::*;
#(
    parameter int MAX_BITS       = CRC_MAX_BITS,
    parameter int MAX_BYTES      = CRC_MAX_BYTES,
    parameter int MAX_BYTE_WIDTH = CRC_MAX_BYTE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MAX_BITS-1:0]       value,
    input  logic [MAX_BYTE_WIDTH-1:0] bytewidth,
    input  logic                      in_valid,
    output logic [MAX_BITS-1:0]       reflected_value,
    output logic                      out_valid
);

    // Each input byte is reversed once; every candidate reuses these.
    logic [MAX_BYTES-1:0][7:0]          byte_refl;
    // Candidate c_w for window of w bytes lives at index w-1.
    logic [MAX_BYTES-1:0][MAX_BITS-1:0] cand;

    logic [MAX_BYTE_WIDTH-1:0] sel_idx;
    logic [MAX_BITS-1:0]       reflected_value_d, reflected_value_q;
    logic                      out_valid_d, out_valid_q;

    for (genvar b = 0; b < MAX_BYTES; b++) begin : g_byte
        reflect_8n_reflect8 u_reflect8 (
            .in_byte (value[b*8 +: 8]),
            .out_byte(byte_refl[b])
        );
    end

    // A w-byte window swaps byte order and reverses each byte; bytes above the window are zero.
    for (genvar w = 1; w <= MAX_BYTES; w++) begin : g_cand
        for (genvar j = 0; j < MAX_BYTES; j++) begin : g_slot
            if (j < w) begin : g_in
                assign cand[w-1][j*8 +: 8] = byte_refl[w-1-j];
            end else begin : g_zero
                assign cand[w-1][j*8 +: 8] = 8'h00;
            end
        end
    end

    // Select the candidate for the clamped window and load it only when qualified.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        reflected_value_d = reflected_value_q;
        out_valid_d       = in_valid;
        sel_idx           = MAX_BYTE_WIDTH'(window_bytes(int'(bytewidth), MAX_BYTES) - 1);
        if (in_valid) begin
            reflected_value_d = cand[sel_idx];
        end
    end

    // Output register and valid flop; reset clears both asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reflected_value_q <= '0;
            out_valid_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            reflected_value_q <= reflected_value_d;
            out_valid_q       <= out_valid_d;
        end
    end

    assign reflected_value = reflected_value_q;
    assign out_valid       = out_valid_q;

endmodule

// File: tb/tb_reflect_8n.sv
// Directed and randomized checks for reflect_8n.
module tb_reflect_8n;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [31:0] value;
    logic [1:0]  bytewidth;
    logic        in_valid;
    logic [31:0] reflected_value;
    logic        out_valid;

    int errors;
    int checks;

    reflect_8n dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .value          (value),
        .bytewidth      (bytewidth),
        .in_valid       (in_valid),
        .reflected_value(reflected_value),
        .out_valid      (out_valid)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Bit-level reference: reverse the low L bits, zero above.
    function automatic logic [31:0] model(input logic [31:0] v, input logic [1:0] bw);
        logic [31:0] r;
        int l;
        l = 8 * (int'(bw) + 1);
        r = '0;
        for (int i = 0; i < l; i++) r[i] = v[l-1-i];
        return r;
    endfunction

    function automatic logic [31:0] mask_l(input logic [31:0] v, input logic [1:0] bw);
        logic [31:0] r;
        int l;
        l = 8 * (int'(bw) + 1);
        r = '0;
        for (int i = 0; i < l; i++) r[i] = v[i];
        return r;
    endfunction

    // Drive one qualified word at the falling edge, then sample just after the next rising edge.
    task automatic apply_and_check(input string name, input logic [31:0] v, input logic [1:0] bw,
                                   input logic [31:0] exp);
        @(negedge clk);
        value = v; bytewidth = bw; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (reflected_value !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %h valid=%b, want %h valid=1", name, reflected_value, out_valid, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; value = 32'hDEAD_BEEF; bytewidth = 2'd3;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (reflected_value !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got %h valid=%b, want 00000000 valid=0", reflected_value, out_valid);
        end
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (reflected_value !== 32'h0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %h valid=%b, want 00000000 valid=0", c, reflected_value, out_valid);
            end
        end
    endtask

    task automatic test_single_byte();
        apply_and_check("byte_0x01", 32'h0000_0001, 2'd0, 32'h0000_0080);
        apply_and_check("byte_upper_ignored", 32'hFFFF_FF0F, 2'd0, 32'h0000_00F0);
    endtask

    task automatic test_multi_byte();
        apply_and_check("two_bytes", 32'h1234_5678, 2'd1, 32'h0000_1E6A);
        apply_and_check("three_bytes", 32'hFF00_0001, 2'd2, 32'h0080_0000);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        value = 32'h0000_0001; bytewidth = 2'd3; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (reflected_value !== 32'h8000_0000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got %h valid=%b, want 80000000 valid=1", reflected_value, out_valid);
        end
        value = 32'h04C1_1DB7; bytewidth = 2'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (reflected_value !== 32'hEDB8_8320 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got %h valid=%b, want edb88320 valid=1", reflected_value, out_valid);
        end
    endtask

    task automatic test_hold();
        // Last captured result is EDB88320 from the back-to-back pair.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            value = 32'h1111_1111 * (c + 1); bytewidth = 2'(c);
            in_valid = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (reflected_value !== 32'hEDB8_8320 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got %h valid=%b, want edb88320 valid=0", c, reflected_value, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        @(negedge clk);
        value = 32'h0000_00FF; bytewidth = 2'd3; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (reflected_value !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got %h valid=%b, want 00000000 valid=0", reflected_value, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (reflected_value !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_edge: got %h valid=%b, want 00000000 valid=0", reflected_value, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (reflected_value !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: got %h valid=%b, want 00000000 valid=0", reflected_value, out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_val;
        logic        exp_vld;
        logic [31:0] vals  [200];
        logic [1:0]  bws   [200];
        logic [31:0] outs  [200];
        exp_val = 32'h0;
        exp_vld = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] v;
            logic [1:0]  bw;
            logic        iv;
            @(negedge clk);
            if (n > 0) begin
                checks++;
                if (reflected_value !== exp_val || out_valid !== exp_vld) begin
                    errors++;
                    $display("FAIL random[%0d]: got %h valid=%b, want %h valid=%b",
                             n, reflected_value, out_valid, exp_val, exp_vld);
                end
            end
            v  = $urandom;
            bw = 2'($urandom_range(0, 3));
            iv = ($urandom_range(0, 3) != 0);
            value = v; bytewidth = bw; in_valid = iv;
            if (iv) exp_val = model(v, bw);
            exp_vld = iv;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (reflected_value !== exp_val || out_valid !== exp_vld) begin
            errors++;
            $display("FAIL random_last: got %h valid=%b, want %h valid=%b", reflected_value, out_valid, exp_val, exp_vld);
        end
        // Reflect fresh words, then feed each result back with the same bytewidth.
        for (int n = 0; n < 200; n++) begin
            vals[n] = $urandom;
            bws[n]  = 2'($urandom_range(0, 3));
            @(negedge clk);
            value = vals[n]; bytewidth = bws[n]; in_valid = 1'b1;
            @(posedge clk); #1;
            outs[n] = reflected_value;
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            value = outs[n]; bytewidth = bws[n]; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (reflected_value !== mask_l(vals[n], bws[n]) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL involution[%0d]: got %h valid=%b, want %h valid=1",
                         n, reflected_value, out_valid, mask_l(vals[n], bws[n]));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clk_en = 1'b0;
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_back_to_back();
        test_hold();
        test_reset_mid_stream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
